transmitter_core: RTL and testbench

TRANSMITTER_CORE -- requirements
Module: transmitter_core

---
 rtl/transmitter_core_if.sv | 9 +
 rtl/transmitter_core.sv | 116 +++++++++++
 tb/tb_transmitter_core.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/transmitter_core_if.sv
// Byte handshake between a producer (master) and the UART transmitter core (slave).
interface transmitter_core_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/transmitter_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define TX_PARITY_EN to insert the even-parity bit (8E1); the default build is 8N1.
module transmitter_core #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  transmitter_core_if.slave  tx_if,
  output logic               serial_data_out,
  output logic               busy
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             line_q;
  logic             ready_q;
  logic             busy_q;

  logic accept;
  logic bit_end;

  assign accept          = tx_if.tx_valid && ready_q;
  assign bit_end         = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign tx_if.tx_ready  = ready_q;
  assign serial_data_out = line_q;
  assign busy            = busy_q;

  // Frame sequencer; the line value for each bit is registered on the edge that enters it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q   <= S_START;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= tx_if.tx_data;
            line_q    <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            line_q  <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
              state_q <= S_PARITY;
              line_q  <= ^shift_q;
`else
              state_q <= S_STOP;
              line_q  <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              line_q    <= shift_q[bit_idx_q + 3'd1];
            end
          end
        end
`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            line_q  <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          line_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter_core.sv
// Bench for transmitter_core: two instances (CLK_DIV=4 and CLK_DIV=2) checked against a bit-level frame model.
module tb_transmitter_core;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DIV_B = 2;
`ifdef TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic line_a, busy_a, line_b, busy_b;

  transmitter_core_if if_a ();
  transmitter_core_if if_b ();

  transmitter_core #(.CLK_DIV(DIV_A)) dut_a (
    .sys_clk(clk), .rst_n(rst_n), .tx_if(if_a), .serial_data_out(line_a), .busy(busy_a)
  );
  transmitter_core #(.CLK_DIV(DIV_B)) dut_b (
    .sys_clk(clk), .rst_n(rst_n), .tx_if(if_b), .serial_data_out(line_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input bit sel);
    return sel ? line_b : line_a;
  endfunction
  function automatic logic ready_of(input bit sel);
    return sel ? if_b.tx_ready : if_a.tx_ready;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) if_b.tx_valid = v;
    else     if_a.tx_valid = v;
  endtask
  task automatic set_data(input bit sel, input logic [7:0] d);
    if (sel) if_b.tx_data = d;
    else     if_a.tx_data = d;
  endtask

  // Reference frame: bit periods in line order (start, d0..d7, [parity], stop).
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    int unsigned v;
    v = 32'(b);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = 1'((v >> i) % 2);
`ifdef TX_PARITY_EN
    f[9] = 1'($countones(b) % 2);
`endif
    return f;
  endfunction

  // Samples one whole frame starting at the negedge after the accept edge.
  task automatic collect(input bit sel, input logic [7:0] exp, input bit scramble,
                         input bit keep_valid, input logic [7:0] mid_data, input string tag);
    logic [10:0] fb;
    logic [7:0]  decoded;
    logic [3:0]  obs;
    int unsigned div;
    int          ready_low;
    div       = sel ? DIV_B : DIV_A;
    fb        = frame_bits(exp);
    decoded   = '0;
    ready_low = 0;
    for (int k = 0; k < int'(NBITS); k++) begin
      obs = '0;
      for (int c = 0; c < int'(div); c++) begin
        @(negedge clk);
        if (scramble && k < int'(NBITS) - 1) begin
          set_valid(sel, 1'($urandom));
          set_data(sel, 8'($urandom));
        end else if (c == 0 && (k == 0 || k == int'(NBITS) - 1)) begin
          set_valid(sel, keep_valid);
        end
        if (!scramble && c == 0 && k == int'(NBITS) / 2) set_data(sel, mid_data);
        obs = {obs[2:0], line_of(sel)};
        if (!ready_of(sel) && busy_of(sel)) ready_low++;
      end
      if (k >= 1 && k <= 8) decoded[k-1] = obs[0];
      check_eq($sformatf("%s bit%0d", tag, k), 32'(obs), fb[k] ? 32'((1 << div) - 1) : 32'd0);
    end
    check_eq($sformatf("%s busy_cycles", tag), 32'(ready_low), 32'(NBITS * div));
    check_eq($sformatf("%s byte", tag), 32'(decoded), 32'(exp));
  endtask

  task automatic wait_ready(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_of(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input bit scramble,
                      input logic [7:0] mid_data, input string tag);
    bit ok;
    wait_ready(sel, ok);
    if (ok) begin
      set_valid(sel, 1'b1);
      set_data(sel, b);
      collect(sel, b, scramble, 1'b0, mid_data, tag);
    end
  endtask

  initial begin
    bit ok;
    int high_cnt;
    rst_n = 1'b0;
    if_a.tx_valid = 1'b0; if_a.tx_data = 8'h00;
    if_b.tx_valid = 1'b0; if_b.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset line", 32'(line_a), 32'd1);
    check_eq("reset ready", 32'(if_a.tx_ready), 32'd1);
    check_eq("reset busy", 32'(busy_a), 32'd0);

    // Release with valid already up: first edge after release accepts.
    rst_n = 1'b1;
    set_valid(0, 1'b1);
    set_data(0, 8'hA5);
    collect(0, 8'hA5, 1'b0, 1'b0, 8'h00, "a5");

    send(0, 8'h07, 1'b0, 8'h00, "07");

    // Back-to-back with valid held: exactly one idle-high cycle between frames.
    wait_ready(0, ok);
    if (ok) begin
      set_valid(0, 1'b1);
      set_data(0, 8'h55);
      collect(0, 8'h55, 1'b0, 1'b1, 8'h0F, "b2b1");
      @(negedge clk);
      check_eq("b2b gap line", 32'(line_a), 32'd1);
      check_eq("b2b gap ready", 32'(if_a.tx_ready), 32'd1);
      collect(0, 8'h0F, 1'b0, 1'b0, 8'hF0, "b2b2");
    end

    send(0, 8'h3C, 1'b0, 8'hFF, "3c_mid_ff");

    // Reset during bit 3 of 0x81.
    wait_ready(0, ok);
    if (ok) begin
      set_valid(0, 1'b1);
      set_data(0, 8'h81);
      @(negedge clk);
      set_valid(0, 1'b0);
      repeat (17) @(negedge clk);
      check_eq("81 bit3 pre", 32'(line_a), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst line", 32'(line_a), 32'd1);
      check_eq("rst ready", 32'(if_a.tx_ready), 32'd1);
      check_eq("rst busy", 32'(busy_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      high_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (line_a && if_a.tx_ready) high_cnt++;
      end
      check_eq("post rst idle", 32'(high_cnt), 32'd30);
      send(0, 8'h42, 1'b0, 8'h00, "42");
    end

    // Random bytes, gaps and input noise while busy.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, b, 1'($urandom), 8'($urandom), $sformatf("rnd%0d", n));
    end

    // Minimum divider.
    send(1, 8'h00, 1'b0, 8'hFF, "div2_00");
    send(1, 8'($urandom), 1'b0, 8'h00, "div2_rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
